// File: rtl/dma_copy_engine.sv
// dma_copy_engine: copies a block of 32-bit words from src to dst over the shared memory/IO bus.
// Optional IO-space guard is built in when DMA_IO_GUARD_EN is defined.
module dma_copy_engine #(
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic               clock,
  input  logic               clr,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               bus_grant,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_we,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int unsigned LatW = $clog2(READ_LAT + 1);

`ifdef DMA_IO_GUARD_EN
  localparam bit IoGuard = 1'b1;
`else
  localparam bit IoGuard = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d, dst_q, dst_d, data_q, data_d, addr_q;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [LatW-1:0]    lat_q, lat_d;
  logic               err_q, err_d;

  assign mem_wdata = data_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    lat_d    = lat_q;
    data_d   = data_q;
    err_d    = err_q;
    mem_addr = addr_q;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        done = (state_q == StDone);
        if (state_q == StDone) state_d = StIdle;
        if (start) begin
          src_d = src_addr & ~32'd3;
          dst_d = dst_addr & ~32'd3;
          rem_d = word_count;
          lat_d = '0;
          err_d = 1'b0;
          if (IoGuard && (word_count != '0) && src_addr[7]) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRd;
          end
        end
      end

      StRd: begin
        busy = 1'b1;
        // A zero-length transfer passes through RD for one busy cycle without touching the bus.
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (bus_grant) begin
          mem_addr = src_q;
          if (lat_q == LatW'(READ_LAT - 1)) begin
            data_d = mem_rdata;
            lat_d  = '0;
            if (IoGuard && dst_q[7]) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StWr;
            end
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end else begin
          lat_d = '0;
        end
      end

      StWr: begin
        busy = 1'b1;
        if (bus_grant) begin
          mem_addr = dst_q;
          mem_we   = 1'b1;
          src_d    = src_q + 32'd4;
          dst_d    = dst_q + 32'd4;
          rem_d    = rem_q - 1'b1;
          if (rem_q == COUNT_W'(1)) begin
            state_d = StDone;
          end else if (IoGuard && src_d[7]) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRd;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      err_q   <= err_d;
      addr_q  <= mem_addr;
    end
  end

endmodule
